// File: rtl/hazard_pkg.sv
// Shared register-address types and constants for ID-stage hazard logic
// (scoreboard, decoder, forwarding unit).
package hazard_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned RUN_CNT_W  = 10;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t X0 = '0;

endpackage

// File: rtl/hazard_scoreboard_stall_watchdog.sv
// Consecutive-stall run counter with a sticky timeout flag.
// The counter holds at TIMEOUT instead of wrapping.
module stall_watchdog
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    output logic timeout_err
);

    localparam logic [RUN_CNT_W-1:0] LIMIT = RUN_CNT_W'(TIMEOUT);

    logic [RUN_CNT_W-1:0] run_q;
    logic [RUN_CNT_W-1:0] run_d;
    logic                 err_q;

    always_comb begin
        run_d = '0;
        if (stall) begin
            run_d = (run_q == LIMIT) ? run_q : run_q + 1'b1;
        end
    end

    // Flag is raised on the same edge the counter arrives at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
            err_q <= 1'b0;
        end else begin
            run_q <= run_d;
            err_q <= err_q | (run_d == LIMIT);
        end
    end

    assign timeout_err = err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: stalls ID on RAW/WAW against in-flight long-latency writes.
// Optional macro WB_BYPASS_EN: a same-cycle writeback releases the stall.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS    = hazard_pkg::NUM_REGS,
    parameter int unsigned REG_ADDR_W  = hazard_pkg::REG_ADDR_W,
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned STALL_CNT_W = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_addr,
    input  logic [NUM_SRC-1:0]            rs_valid,
    input  logic [REG_ADDR_W-1:0]         rd_addr,
    input  logic                          rd_long,
    input  logic                          wb_valid,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    input  logic                          flush,
    output logic                          do_stall,
    output logic [NUM_REGS-1:0]           busy,
    output logic [STALL_CNT_W-1:0]        stall_cycles,
    output logic                          timeout_err
);

    import hazard_pkg::*;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = REG_ADDR_W'(X0);

    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;
    logic [NUM_REGS-1:0]    busy_eff;
    logic [REG_ADDR_W-1:0]  src;
    logic                   raw;
    logic                   waw;
    logic                   fire;
    logic                   wb_hit;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign wb_hit = wb_valid && (wb_rd != ZERO_REG);

`ifdef WB_BYPASS_EN
    always_comb begin
        busy_eff = busy_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (wb_valid && (wb_rd == REG_ADDR_W'(r))) begin
                busy_eff[r] = 1'b0;
            end
        end
    end
`else
    assign busy_eff = busy_q;
`endif

    always_comb begin
        raw = 1'b0;
        src = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src = rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
            if (rs_valid[i] && (src != ZERO_REG) && busy_eff[src]) begin
                raw = 1'b1;
            end
        end
    end

    assign waw      = rd_long && (rd_addr != ZERO_REG) && busy_eff[rd_addr];
    assign do_stall = id_valid && !flush && (raw || waw);
    assign fire     = id_valid && !do_stall && !flush;

    // Clear is applied before set so an issue to the register being written back wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_hit) begin
                busy_d[wb_rd] = 1'b0;
            end
            if (fire && rd_long && (rd_addr != ZERO_REG)) begin
                busy_d[rd_addr] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (do_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign busy         = busy_q;
    assign stall_cycles = stall_cnt_q;

    stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (do_stall),
        .timeout_err (timeout_err)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a behavioural model queues expected
// post-edge state, checked one step after each rising edge.
module tb_hazard_scoreboard;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  rs_addr;
    logic [1:0]  rs_valid;
    logic [4:0]  rd_addr;
    logic        rd_long;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        do_stall;
    logic [31:0] busy;
    logic [15:0] stall_cycles;
    logic        timeout_err;

    hazard_scoreboard #(
        .NUM_REGS    (32),
        .REG_ADDR_W  (5),
        .NUM_SRC     (2),
        .STALL_CNT_W (16),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .rs_addr      (rs_addr),
        .rs_valid     (rs_valid),
        .rd_addr      (rd_addr),
        .rd_long      (rd_long),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .flush        (flush),
        .do_stall     (do_stall),
        .busy         (busy),
        .stall_cycles (stall_cycles),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] busy;
        logic [15:0] sc;
        logic        to;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [31:0] m_busy = '0;
    logic [15:0] m_sc   = '0;
    int unsigned m_run  = 0;
    logic        m_to   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic m_eff(input logic [4:0] r);
        logic b;
        b = m_busy[r];
`ifdef WB_BYPASS_EN
        if (wb_valid && wb_rd == r) b = 1'b0;
`endif
        return b;
    endfunction

    // Check combinational stall, then queue the expected state after the coming edge.
    task automatic step(input string tag);
        logic        raw, waw, exp_stall, fire;
        logic [4:0]  s;
        logic [31:0] nb;
        exp_t        e;
        #1;
        raw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s = rs_addr[i*5 +: 5];
            if (rs_valid[i] && s != 5'd0 && m_eff(s)) raw = 1'b1;
        end
        waw = rd_long && rd_addr != 5'd0 && m_eff(rd_addr);
        exp_stall = id_valid && !flush && (raw || waw);
        fire = id_valid && !exp_stall && !flush;
        check({tag, "/stall"}, {31'd0, do_stall}, {31'd0, exp_stall});

        nb = m_busy;
        if (flush) nb = '0;
        else begin
            if (wb_valid && wb_rd != 5'd0) nb[wb_rd] = 1'b0;
            if (fire && rd_long && rd_addr != 5'd0) nb[rd_addr] = 1'b1;
        end
        m_busy = nb;
        if (exp_stall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        if (exp_stall) m_run = (m_run == TO) ? m_run : m_run + 1;
        else m_run = 0;
        if (m_run == TO) m_to = 1'b1;

        e.tag  = tag;
        e.busy = m_busy;
        e.sc   = m_sc;
        e.to   = m_to;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.tag, "/busy"}, busy, e.busy);
            check({e.tag, "/stall_cycles"}, {16'd0, stall_cycles}, {16'd0, e.sc});
            check({e.tag, "/timeout"}, {31'd0, timeout_err}, {31'd0, e.to});
        end
    end

    task automatic idle();
        id_valid = 1'b0; rs_addr = '0; rs_valid = '0; rd_addr = '0;
        rd_long = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        idle();
        id_valid = 1'b1; rd_long = 1'b1; rd_addr = rd;
    endtask

    task automatic consume(input logic [4:0] rs);
        idle();
        id_valid = 1'b1; rs_addr = {5'd0, rs}; rs_valid = 2'b01;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #2;
        check("reset/busy", busy, 32'd0);
        check("reset/stall_cycles", {16'd0, stall_cycles}, 32'd0);
        check("reset/timeout", {31'd0, timeout_err}, 32'd0);
        check("reset/stall", {31'd0, do_stall}, 32'd0);
        #1 rst_n = 1'b1;

        // Load-use on x5, released by writeback
        issue_long(5'd5);                      step("t1_issue");
        consume(5'd5);                         step("t1_use0");
        step("t1_use1");
        wb_valid = 1'b1; wb_rd = 5'd5;         step("t1_wb");
        wb_valid = 1'b0;                       step("t1_after");
        idle();                                step("t1_idle");

        // x0 never busy, never stalls
        issue_long(5'd0);                      step("t2_issue_x0");
        idle(); id_valid = 1'b1; rs_valid = 2'b11; rd_long = 1'b1;
        step("t2_use_x0");

        // WAW on x7
        issue_long(5'd7);                      step("t3_issue");
        issue_long(5'd7);                      step("t3_waw0");
        step("t3_waw1");
        wb_valid = 1'b1; wb_rd = 5'd7;         step("t3_wb");
        wb_valid = 1'b0;                       step("t3_after");
        idle(); wb_valid = 1'b1; wb_rd = 5'd7; step("t3_drain");

        // Same-edge set and clear of x9
        issue_long(5'd9); wb_valid = 1'b1; wb_rd = 5'd9; step("t4_setclr");
        idle(); wb_valid = 1'b1; wb_rd = 5'd9; step("t4_clear");

        // Flush while x3, x4 busy
        issue_long(5'd3);                      step("t5_issue3");
        issue_long(5'd4);                      step("t5_issue4");
        issue_long(5'd6); rs_addr = {5'd4, 5'd3}; rs_valid = 2'b11; flush = 1'b1;
        step("t5_flush");
        idle(); id_valid = 1'b1; rs_addr = {5'd4, 5'd3}; rs_valid = 2'b11;
        step("t5_post");

        // Timeout after TO consecutive stalls; sticky afterwards
        issue_long(5'd10);                     step("t6_issue");
        consume(5'd10);
        for (int i = 0; i < 5; i++) step("t6_hold");
        idle(); wb_valid = 1'b1; wb_rd = 5'd10; step("t6_wb");
        idle();                                step("t6_sticky");

        // Random traffic over a small register window
        for (int i = 0; i < 60; i++) begin
            id_valid = 1'($urandom_range(0, 1));
            rs_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rs_valid = 2'($urandom_range(0, 3));
            rd_addr  = 5'($urandom_range(0, 7));
            rd_long  = 1'($urandom_range(0, 1));
            wb_valid = 1'($urandom_range(0, 1));
            wb_rd    = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 9) == 0);
            step("rnd");
        end

        // Asynchronous reset in the middle of a stall
        idle(); wb_valid = 1'b1; wb_rd = 5'd0; flush = 1'b1; step("t7_flush");
        issue_long(5'd11);                     step("t7_issue");
        consume(5'd11);                        step("t7_hold");
        #1;
        check("t7_pre_reset/stall", {31'd0, do_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t7_reset/busy", busy, 32'd0);
        check("t7_reset/stall_cycles", {16'd0, stall_cycles}, 32'd0);
        check("t7_reset/timeout", {31'd0, timeout_err}, 32'd0);
        check("t7_reset/stall", {31'd0, do_stall}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
